// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } ctrl_state_e;

  // Per-cycle control bundle driven toward the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic halted;
  } ctrl_out_t;

  // Free-running pipeline: every stage advances, nothing squashed.
  function automatic ctrl_out_t run_outs();
    ctrl_out_t o;
    o              = '0;
    o.pc_en        = 1'b1;
    o.if_id_en     = 1'b1;
    o.ex_mem_en    = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze,
// syscall halt, plus saturating performance counters.
module stall_flush_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             nop_lock_id,
  input  logic             branch_taken_ex,
  input  logic             syscall_halt_id,
  input  logic             resume,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_e state_q, state_d;
  ctrl_state_e ret_q, ret_d;
  ctrl_state_e eff_state;
  ctrl_out_t   ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // A memory wait is transparent: once it ends, decisions resume as in the
  // state the wait interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    ret_d   = ret_q;

    if (rst) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      state_d          = RUN;
      ret_d            = RUN;
    end else if (state_q == HALT) begin
      if (resume) begin
        ctl     = run_outs();
        state_d = RUN;
      end else begin
        ctl.ex_mem_en    = 1'b1;
        ctl.id_ex_bubble = 1'b1;
        ctl.halted       = 1'b1;
      end
    end else if (!mem_ready) begin
      state_d = MEM_WAIT;
      ret_d   = (state_q == MEM_WAIT) ? ret_q : state_q;
    end else if (syscall_halt_id) begin
      // halted rises with the entry cycle so it tracks the bubbles issued.
      ctl.ex_mem_en    = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      ctl.halted       = 1'b1;
      state_d          = HALT;
    end else if (branch_taken_ex) begin
      ctl              = run_outs();
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      state_d          = RUN;
    end else if (nop_lock_id && (eff_state == RUN)) begin
      ctl.ex_mem_en    = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      state_d          = LU_STALL;
    end else begin
      ctl     = run_outs();
      state_d = RUN;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign halted       = ctl.halted;

  sat_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctl.pc_en),
    .count (stall_cnt)
  );

  sat_counter u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl.id_ex_bubble),
    .count (bubble_cnt)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl.if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Scoreboard bench for stall_flush_ctrl: driver queues expectations, monitor checks them.
module tb_stall_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nop_lock_id = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic        syscall_halt_id = 1'b0;
  logic        resume = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_bubble, halted;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_flush_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .nop_lock_id     (nop_lock_id),
    .branch_taken_ex (branch_taken_ex),
    .syscall_halt_id (syscall_halt_id),
    .resume          (resume),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .ex_mem_en       (ex_mem_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .bubble_cnt      (bubble_cnt),
    .flush_cnt       (flush_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  outs;
    bit          chk_cnt;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] f;
  } exp_t;

  exp_t exp_q[$];

  // Input vectors {rst, lock, branch, syscall, resume, mem_ready}
  localparam logic [5:0] I_RST   = 6'b100001;
  localparam logic [5:0] I_IDLE  = 6'b000001;
  localparam logic [5:0] I_LOCK  = 6'b010001;
  localparam logic [5:0] I_BR    = 6'b001001;
  localparam logic [5:0] I_BRLK  = 6'b011001;
  localparam logic [5:0] I_SYS   = 6'b000101;
  localparam logic [5:0] I_SYSBR = 6'b001101;
  localparam logic [5:0] I_RES   = 6'b000011;
  localparam logic [5:0] I_MW0   = 6'b000000;
  localparam logic [5:0] I_MWBR  = 6'b001000;
  localparam logic [5:0] I_MWSYS = 6'b000100;

  // Output vectors {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_bubble, halted}
  localparam logic [5:0] O_RUN = 6'b111000;
  localparam logic [5:0] O_RST = 6'b000110;
  localparam logic [5:0] O_LU  = 6'b001010;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_MW  = 6'b000000;
  localparam logic [5:0] O_HLT = 6'b001011;

  task automatic cyc(input string name, input logic [5:0] in, input logic [5:0] outs,
                     input bit chk, input logic [31:0] s, input logic [31:0] b,
                     input logic [31:0] f);
    exp_t e;
    @(negedge clk);
    {rst, nop_lock_id, branch_taken_ex, syscall_halt_id, resume, mem_ready} = in;
    e.name = name; e.outs = outs; e.chk_cnt = chk; e.s = s; e.b = b; e.f = f;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational in the inputs, so sample mid-low-phase.
  initial begin
    exp_t e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_bubble, halted};
        checks++;
        if (got !== e.outs) begin
          errors++;
          $display("FAIL %s outs: got %b expected %b", e.name, got, e.outs);
        end
        if (e.chk_cnt) begin
          checks++;
          if (stall_cnt !== e.s || bubble_cnt !== e.b || flush_cnt !== e.f) begin
            errors++;
            $display("FAIL %s counters: got s=%h b=%h f=%h expected s=%h b=%h f=%h",
                     e.name, stall_cnt, bubble_cnt, flush_cnt, e.s, e.b, e.f);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc("reset0",    I_RST,   O_RST, 0, 0, 0, 0);
    cyc("reset1",    I_RST,   O_RST, 1, 0, 0, 0);
    cyc("idle",      I_IDLE,  O_RUN, 1, 0, 0, 0);
    // Load-use held two cycles: only the first stalls
    cyc("lu1",       I_LOCK,  O_LU,  1, 0, 0, 0);
    cyc("lu2",       I_LOCK,  O_RUN, 1, 1, 1, 0);
    cyc("lu_after",  I_IDLE,  O_RUN, 1, 1, 1, 0);
    cyc("rst_a",     I_RST,   O_RST, 1, 1, 1, 0);
    // Branch beats lock in the same cycle
    cyc("brlk",      I_BRLK,  O_BR,  1, 0, 0, 0);
    cyc("br_after",  I_IDLE,  O_RUN, 1, 0, 1, 1);
    cyc("lu_br_a",   I_LOCK,  O_LU,  1, 0, 1, 1);
    cyc("lu_br_b",   I_BR,    O_BR,  1, 1, 2, 1);
    cyc("lu_br_end", I_IDLE,  O_RUN, 1, 1, 3, 2);
    cyc("rst_b",     I_RST,   O_RST, 1, 1, 3, 2);
    // Memory wait entered from LU_STALL; stale lock ignored on return
    cyc("mw_lock",   I_LOCK,  O_LU,  1, 0, 0, 0);
    cyc("mw1",       I_MW0,   O_MW,  1, 1, 1, 0);
    cyc("mw2",       I_MW0,   O_MW,  1, 2, 1, 0);
    cyc("mw3",       I_MW0,   O_MW,  1, 3, 1, 0);
    cyc("mw_ret",    I_LOCK,  O_RUN, 1, 4, 1, 0);
    cyc("mw_after",  I_IDLE,  O_RUN, 1, 4, 1, 0);
    cyc("rst_c",     I_RST,   O_RST, 1, 4, 1, 0);
    // Memory beats branch and syscall; pending branch honoured on return
    cyc("mwbr1",     I_MWBR,  O_MW,  1, 0, 0, 0);
    cyc("mwbr2",     I_BR,    O_BR,  1, 1, 0, 0);
    cyc("mwsys",     I_MWSYS, O_MW,  1, 1, 1, 1);
    cyc("mwsys_end", I_IDLE,  O_RUN, 1, 2, 1, 1);
    cyc("rst_d",     I_RST,   O_RST, 1, 2, 1, 1);
    // Halt, five ignored-event cycles, resume
    cyc("hlt_sys",   I_SYS,   O_HLT, 1, 0, 0, 0);
    cyc("hlt_i1",    I_IDLE,  O_HLT, 1, 1, 1, 0);
    cyc("hlt_i2",    I_BR,    O_HLT, 1, 2, 2, 0);
    cyc("hlt_i3",    I_MW0,   O_HLT, 1, 3, 3, 0);
    cyc("hlt_i4",    I_LOCK,  O_HLT, 1, 4, 4, 0);
    cyc("hlt_i5",    I_SYS,   O_HLT, 1, 5, 5, 0);
    cyc("hlt_res",   I_RES,   O_RUN, 1, 6, 6, 0);
    cyc("hlt_after", I_IDLE,  O_RUN, 1, 6, 6, 0);
    cyc("rst_e",     I_RST,   O_RST, 1, 6, 6, 0);
    // Syscall beats branch; reset while halted
    cyc("sysbr",     I_SYSBR, O_HLT, 1, 0, 0, 0);
    cyc("h_idle",    I_IDLE,  O_HLT, 1, 1, 1, 0);
    cyc("h_rst",     I_RST,   O_RST, 1, 2, 2, 0);
    cyc("post_rst",  I_IDLE,  O_RUN, 1, 0, 0, 0);
    cyc("post_lock", I_LOCK,  O_LU,  1, 0, 0, 0);
    cyc("post_end",  I_IDLE,  O_RUN, 1, 1, 1, 0);
    // Saturation of the stall counter
    cyc("rst_f",     I_RST,   O_RST, 1, 1, 1, 0);
    cyc("sat_idle",  I_IDLE,  O_RUN, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    cyc("sat_lock",  I_LOCK,  O_LU,  1, 32'hFFFF_FFFE, 0, 0);
    cyc("sat_w1",    I_MW0,   O_MW,  1, 32'hFFFF_FFFF, 1, 0);
    cyc("sat_w2",    I_MW0,   O_MW,  1, 32'hFFFF_FFFF, 1, 0);
    cyc("sat_ret",   I_IDLE,  O_RUN, 1, 32'hFFFF_FFFF, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
